// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch unit
package fetch_pkg;

  localparam int unsigned INSTR_BYTES = 4;
  localparam int unsigned FETCH_XLEN  = 32;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - two-entry in-order {pc, instr} FIFO with flush
// Entry 0 is always the head, so the outputs come straight from a register.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter type entry_t = fetch_entry_t
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic       flush_i,
  input  entry_t     wdata_i,
  output entry_t     head_o,
  output logic [1:0] count_o
);

  entry_t     e0_q;
  entry_t     e1_q;
  logic [1:0] count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      e0_q    <= '0;
      e1_q    <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      count_q <= '0;
    end else begin
      case ({push_i, pop_i})
        2'b10: begin
          if (count_q == 2'd0) e0_q <= wdata_i;
          else                 e1_q <= wdata_i;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          e0_q    <= e1_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            e0_q <= wdata_i;
          end else begin
            e0_q <= e1_q;
            e1_q <= wdata_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign head_o  = e0_q;
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding instruction fetch with redirect drain
// Optional FETCH_PERF_EN adds perf_fetched / perf_stalled counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_rvalid,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             stall,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_instr,
  output logic [WIDTH-1:0] out_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]      perf_fetched,
  output logic [31:0]      perf_stalled
`endif
);

  // Same layout as fetch_entry_t, sized by WIDTH.
  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] instr;
  } entry_t;

  fetch_state_t     state_q;
  logic [WIDTH-1:0] fetch_pc_q;
  logic [WIDTH-1:0] fetch_pc_d;
  logic [WIDTH-1:0] inflight_pc_q;
  logic             inflight_q;
  logic             resp_now;
  logic             pop;
  logic             push;
  logic [1:0]       count;
  logic [1:0]       occ;
  entry_t           head;
  entry_t           wentry;

  assign resp_now   = imem_rvalid && inflight_q;
  assign pop        = out_valid && !stall && !redirect;
  assign push       = resp_now && (state_q == RUN) && !redirect;
  assign occ        = count - 2'(pop) + 2'(push);
  assign fetch_pc_d = fetch_pc_q + WIDTH'(INSTR_BYTES);

  // A response retiring this cycle frees the single outstanding slot for a new request.
  assign imem_req  = !reset && (state_q == RUN) && (!inflight_q || resp_now)
                     && (occ < 2'd2) && !redirect;
  assign imem_addr = fetch_pc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= RUN;
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else if (redirect) begin
      fetch_pc_q <= redirect_pc;
      if (inflight_q && !imem_rvalid) begin
        state_q <= DRAIN;
      end else begin
        state_q    <= RUN;
        inflight_q <= 1'b0;
      end
    end else if (state_q == DRAIN) begin
      if (imem_rvalid) begin
        state_q    <= RUN;
        inflight_q <= 1'b0;
      end
    end else if (imem_req) begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= fetch_pc_q;
      inflight_q    <= 1'b1;
    end else if (resp_now) begin
      inflight_q <= 1'b0;
    end
  end

  assign wentry = '{pc: inflight_pc_q, instr: imem_rdata};

  fetch_buffer #(
    .entry_t(entry_t)
  ) u_buf (
    .clk_i  (clk),
    .rst_i  (reset),
    .push_i (push),
    .pop_i  (pop),
    .flush_i(redirect),
    .wdata_i(wentry),
    .head_o (head),
    .count_o(count)
  );

  assign out_valid = (count != 2'd0);
  assign out_pc    = head.pc;
  assign out_instr = head.instr;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_stalled_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched_q <= '0;
      perf_stalled_q <= '0;
    end else begin
      if (pop)                perf_fetched_q <= perf_fetched_q + 32'd1;
      if (out_valid && stall) perf_stalled_q <= perf_stalled_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stalled = perf_stalled_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed + randomized bench for fetch_unit with a queue-based reference model
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stalled;
`endif

  fetch_unit #(.WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .out_valid  (out_valid),
    .out_instr  (out_instr),
    .out_pc     (out_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_stalled(perf_stalled)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  int          checks;
  int          failures;
  int          cyc;
  int          mem_lat;
  ent_t        mbuf[$];
  pend_t       pend[$];
  logic [31:0] m_pc;
  logic [31:0] m_ipc;
  bit          m_inflight;
  bit          m_drain;
  int unsigned m_fetched;
  int unsigned m_stalled;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == 32'h0) return 32'h1111_1111;
    if (a == 32'h4) return 32'h2222_2222;
    return {a[15:0], a[31:16]} ^ 32'hA5C3_0F1E;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mbuf.delete();
    pend.delete();
    m_pc       = 32'h0;
    m_ipc      = 32'h0;
    m_inflight = 0;
    m_drain    = 0;
    m_fetched  = 0;
    m_stalled  = 0;
  endtask

  // One clock cycle: drive at the falling edge, compare 1 time unit later, advance the model.
  task automatic step(input bit rst_v, input bit st, input bit rd, input logic [31:0] rpc,
                      input bit force_rv);
    bit          rv;
    bit          pop;
    bit          push;
    bit          ereq;
    int          occ;
    int          lat;
    logic [31:0] rdat;
    @(negedge clk);
    rv   = 0;
    rdat = 32'h0;
    if (rst_v) begin
      model_reset();
    end else if (force_rv) begin
      rv   = 1;
      rdat = 32'hDEAD_BEEF;
    end else if (pend.size() > 0 && pend[0].due <= cyc) begin
      rv   = 1;
      rdat = mem_data(pend[0].addr);
      void'(pend.pop_front());
    end
    reset       = rst_v;
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    imem_rvalid = rv;
    imem_rdata  = rdat;
    #1;
    if (rst_v) begin
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_pc", out_pc, 32'h0);
      chk("rst_instr", out_instr, 32'h0);
      cyc++;
      return;
    end
    pop  = (mbuf.size() > 0) && !st && !rd;
    push = rv && m_inflight && !m_drain && !rd;
    occ  = int'(mbuf.size()) - (pop ? 1 : 0) + (push ? 1 : 0);
    ereq = !m_drain && (!m_inflight || rv) && (occ < 2) && !rd;
    chk("out_valid", 32'(out_valid), 32'(mbuf.size() > 0));
    if (mbuf.size() > 0) begin
      chk("out_pc", out_pc, mbuf[0].pc);
      chk("out_instr", out_instr, mbuf[0].instr);
    end
    chk("imem_req", 32'(imem_req), 32'(ereq));
    if (ereq) chk("imem_addr", imem_addr, m_pc);
    if (pop) m_fetched++;
    if (mbuf.size() > 0 && st) m_stalled++;
    if (rd) begin
      mbuf.delete();
      m_pc = rpc;
      if (m_inflight && !rv) begin
        m_drain = 1;
      end else begin
        m_drain    = 0;
        m_inflight = 0;
      end
    end else if (m_drain) begin
      if (rv) begin
        m_drain    = 0;
        m_inflight = 0;
      end
    end else begin
      if (pop) void'(mbuf.pop_front());
      if (push) begin
        mbuf.push_back('{pc: m_ipc, instr: rdat});
        m_inflight = 0;
      end
      if (ereq) begin
        lat = (mem_lat == 0) ? int'($urandom_range(3, 1)) : mem_lat;
        pend.push_back('{addr: m_pc, due: cyc + lat});
        m_inflight = 1;
        m_ipc      = m_pc;
        m_pc       = m_pc + 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      step(0, 0, 0, 32'h0, 0);
      n++;
    end
    chk({tag, "_req_seen"}, 32'(imem_req), 32'd1);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      step(0, 0, 0, 32'h0, 0);
      n++;
    end
    chk({tag, "_valid_seen"}, 32'(out_valid), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held_pc;
    logic [31:0] held_instr;
    logic [31:0] rpc;
    checks      = 0;
    failures    = 0;
    cyc         = 0;
    mem_lat     = 1;
    clk         = 0;
    reset       = 1;
    stall       = 0;
    redirect    = 0;
    redirect_pc = 32'h0;
    imem_rvalid = 0;
    imem_rdata  = 32'h0;
    model_reset();
    #1;
    chk("init_valid", 32'(out_valid), 32'd0);
    chk("init_req", 32'(imem_req), 32'd0);
    chk("init_pc", out_pc, 32'h0);
    chk("init_instr", out_instr, 32'h0);
    step(1, 0, 0, 32'h0, 0);
    step(1, 0, 0, 32'h0, 0);

    // Release with a spurious response in the first cycle; it must be ignored.
    step(0, 0, 0, 32'h0, 1);
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    step(0, 0, 0, 32'h0, 0);
    step(0, 0, 0, 32'h0, 0);
    chk("b2b_pc0", out_pc, 32'h0);
    chk("b2b_instr0", out_instr, 32'h1111_1111);
    step(0, 0, 0, 32'h0, 0);
    chk("b2b_pc4", out_pc, 32'h4);
    chk("b2b_instr4", out_instr, 32'h2222_2222);
    step(0, 0, 0, 32'h0, 0);
    chk("b2b_pc8", out_pc, 32'h8);

    // Fill the buffer under stall, then hold for five cycles.
    step(1, 0, 0, 32'h0, 0);
    step(0, 1, 0, 32'h0, 0);
    step(0, 1, 0, 32'h0, 0);
    step(0, 1, 0, 32'h0, 0);
    held_pc    = mbuf[0].pc;
    held_instr = mbuf[0].instr;
    chk("full_count", 32'(mbuf.size()), 32'd2);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 32'h0, 0);
      chk("stall_req", 32'(imem_req), 32'd0);
      chk("stall_pc", out_pc, held_pc);
      chk("stall_instr", out_instr, held_instr);
    end
    for (int i = 0; i < 8; i++) step(0, 0, 0, 32'h0, 0);

    // Redirect and stall in the same cycle.
    step(0, 1, 1, 32'h200, 0);
    step(0, 0, 0, 32'h0, 0);
    chk("rs_flushed", 32'(out_valid), 32'd0);
    wait_req("rs");
    chk("rs_addr", imem_addr, 32'h200);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 32'h0, 0);

    // Redirect while a 3-cycle request is in flight.
    mem_lat = 3;
    step(1, 0, 0, 32'h0, 0);
    step(0, 0, 0, 32'h0, 0);
    step(0, 0, 1, 32'h100, 0);
    chk("drain_req0", 32'(imem_req), 32'd0);
    step(0, 0, 0, 32'h0, 0);
    chk("drain_state", 32'(dut.state_q == fetch_pkg::DRAIN), 32'd1);
    chk("drain_req1", 32'(imem_req), 32'd0);
    wait_valid("drain");
    chk("drain_pc", out_pc, 32'h100);
    chk("drain_instr", out_instr, mem_data(32'h100));

    // Address wrap at the top of the address space.
    mem_lat = 1;
    step(0, 0, 1, 32'hFFFF_FFFC, 0);
    step(0, 0, 0, 32'h0, 0);
    wait_req("wrap_a");
    chk("wrap_top", imem_addr, 32'hFFFF_FFFC);
    step(0, 0, 0, 32'h0, 0);
    wait_req("wrap_b");
    chk("wrap_zero", imem_addr, 32'h0);

    // Randomized traffic with a mid-stream asynchronous reset.
    mem_lat = 0;
    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) begin
        #2;
        reset = 1;
        #1;
        chk("areset_valid", 32'(out_valid), 32'd0);
        chk("areset_req", 32'(imem_req), 32'd0);
        chk("areset_pc", out_pc, 32'h0);
        chk("areset_instr", out_instr, 32'h0);
`ifdef FETCH_PERF_EN
        chk("areset_perf_f", perf_fetched, 32'h0);
        chk("areset_perf_s", perf_stalled, 32'h0);
`endif
        step(1, 0, 0, 32'h0, 0);
        step(0, 0, 0, 32'h0, 1);
        chk("areset_first_addr", imem_addr, 32'h0);
      end else begin
        rpc = ($urandom_range(7, 0) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
        step(0, $urandom_range(3, 0) == 0, $urandom_range(19, 0) == 0, rpc, 0);
      end
    end
`ifdef FETCH_PERF_EN
    chk("perf_fetched", perf_fetched, m_fetched);
    chk("perf_stalled", perf_stalled, m_stalled);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
